// File: rtl/vga_timing_monitor_if.sv
// rtl/vga_timing_monitor_if.sv - sampled VGA pixel stream (sync, blank, RGB) at pixel rate
interface vga_timing_monitor_if;
    logic       pix_en;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (output pix_en, hs, vs, blank_n, r, g, b);
    modport slave  (input  pix_en, hs, vs, blank_n, r, g, b);
endinterface

// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - VGA timing recovery, geometry check, lock, frame checksum and pixel probe
module vga_timing_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int CNT_W       = 12
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    vga_timing_monitor_if.slave  vid,
    input  logic [9:0]           probe_x_i,
    input  logic [9:0]           probe_y_i,
    output logic [CNT_W-1:0]     h_total_o,
    output logic [CNT_W-1:0]     v_total_o,
    output logic [CNT_W-1:0]     h_active_o,
    output logic [CNT_W-1:0]     v_active_o,
    output logic                 locked_o,
    output logic                 frame_done_o,
    output logic                 err_o,
    output logic [31:0]          frame_sum_o,
    output logic [7:0]           probe_r_o,
    output logic [7:0]           probe_g_o,
    output logic [7:0]           probe_b_o,
    output logic                 probe_valid_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    typedef struct packed {
        logic             s1_hs, s1_vs, s1_bn, prev_hs, prev_vs;
        logic [7:0]       s1_r, s1_g, s1_b;
        logic [CNT_W-1:0] hcnt, xact, vcnt, yact, ref_h, act_w, prev_ref_h, prev_vcnt;
        logic             ref_set, bad, seen, prev_valid;
        logic [31:0]      sum;
        logic [7:0]       cap_r, cap_g, cap_b;
        logic [3:0]       lock_cnt;
        logic [CNT_W-1:0] h_total, v_total, h_active, v_active;
        logic             locked, frame_done, err, probe_valid;
        logic [31:0]      frame_sum;
        logic [7:0]       probe_r, probe_g, probe_b;
    } regs_t;

    state_t           state_q, state_d;
    regs_t            r_q, r_d;
    logic             hs_fall, vs_fall, pix_act, good;
    logic [CNT_W-1:0] line_len, xbase;
    logic [9:0]       pix_sum;
    logic [3:0]       lock_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign hs_fall  = vid.pix_en && r_q.prev_hs && !r_q.s1_hs;
    assign vs_fall  = vid.pix_en && r_q.prev_vs && !r_q.s1_vs;
    assign pix_act  = vid.pix_en && r_q.s1_bn;
    assign line_len = sat_inc(r_q.hcnt);
    assign xbase    = hs_fall ? '0 : r_q.xact;
    assign pix_sum  = {2'b00, r_q.s1_r} + {2'b00, r_q.s1_g} + {2'b00, r_q.s1_b};
    assign lock_inc = r_q.lock_cnt + 4'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_SEARCH;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_q <= '0;
        else         r_q <= r_d;
    end

    always_comb begin
        r_d            = r_q;
        state_d        = state_q;
        r_d.frame_done = 1'b0;
        r_d.err        = 1'b0;
        good           = 1'b0;

        if (vid.pix_en) begin
            r_d.s1_hs   = vid.hs;
            r_d.s1_vs   = vid.vs;
            r_d.s1_bn   = vid.blank_n;
            r_d.s1_r    = vid.r;
            r_d.s1_g    = vid.g;
            r_d.s1_b    = vid.b;
            r_d.prev_hs = r_q.s1_hs;
            r_d.prev_vs = r_q.s1_vs;
            r_d.hcnt    = hs_fall ? '0 : sat_inc(r_q.hcnt);
        end

        // Line end is settled before the pixel and frame logic so a coincident
        // HS/VS fall credits the finished line to the ending frame.
        if (hs_fall) begin
            if (!r_q.ref_set) begin
                r_d.ref_h   = line_len;
                r_d.ref_set = 1'b1;
            end else if (line_len != r_q.ref_h) begin
                r_d.bad = 1'b1;
            end
            if (r_q.xact != '0 && r_q.xact != H_ACT) r_d.bad = 1'b1;
            if (r_q.xact != '0) begin
                r_d.act_w = r_q.xact;
                r_d.yact  = sat_inc(r_q.yact);
            end
            r_d.vcnt = sat_inc(r_q.vcnt);
            r_d.xact = '0;
        end

        if (pix_act) begin
            r_d.sum = r_q.sum + {22'd0, pix_sum};
            if (xbase == CNT_W'(probe_x_i) && r_d.yact == CNT_W'(probe_y_i)) begin
                r_d.cap_r = r_q.s1_r;
                r_d.cap_g = r_q.s1_g;
                r_d.cap_b = r_q.s1_b;
                r_d.seen  = 1'b1;
            end
            r_d.xact = sat_inc(xbase);
        end

        if (vs_fall) begin
            if (state_q == ST_SEARCH) begin
                state_d      = ST_MEASURE;
                r_d.lock_cnt = '0;
            end else begin
                r_d.h_total     = r_d.ref_h;
                r_d.v_total     = r_d.vcnt;
                r_d.h_active    = r_d.act_w;
                r_d.v_active    = r_d.yact;
                r_d.frame_sum   = r_d.sum;
                r_d.probe_r     = r_d.cap_r;
                r_d.probe_g     = r_d.cap_g;
                r_d.probe_b     = r_d.cap_b;
                r_d.probe_valid = r_d.seen;
                r_d.frame_done  = 1'b1;
                // With no earlier frame on record the consistency term passes.
                good = !r_d.bad && r_d.yact == V_ACT && r_d.act_w == H_ACT &&
                       (!r_q.prev_valid ||
                        (r_d.ref_h == r_q.prev_ref_h && r_d.vcnt == r_q.prev_vcnt));
                r_d.prev_ref_h = r_d.ref_h;
                r_d.prev_vcnt  = r_d.vcnt;
                r_d.prev_valid = 1'b1;
                if (state_q == ST_MEASURE) begin
                    if (!good) begin
                        r_d.lock_cnt = '0;
                    end else begin
                        r_d.lock_cnt = lock_inc;
                        if (lock_inc >= LOCK_N) begin
                            state_d    = ST_LOCKED;
                            r_d.locked = 1'b1;
                        end
                    end
                end else if (!good) begin
                    state_d      = ST_MEASURE;
                    r_d.err      = 1'b1;
                    r_d.locked   = 1'b0;
                    r_d.lock_cnt = '0;
                end
            end
            r_d.vcnt    = '0;
            r_d.yact    = '0;
            r_d.ref_h   = '0;
            r_d.ref_set = 1'b0;
            r_d.act_w   = '0;
            r_d.bad     = 1'b0;
            r_d.sum     = '0;
            r_d.seen    = 1'b0;
            r_d.cap_r   = '0;
            r_d.cap_g   = '0;
            r_d.cap_b   = '0;
        end
    end

    assign h_total_o     = r_q.h_total;
    assign v_total_o     = r_q.v_total;
    assign h_active_o    = r_q.h_active;
    assign v_active_o    = r_q.v_active;
    assign locked_o      = r_q.locked;
    assign frame_done_o  = r_q.frame_done;
    assign err_o         = r_q.err;
    assign frame_sum_o   = r_q.frame_sum;
    assign probe_r_o     = r_q.probe_r;
    assign probe_g_o     = r_q.probe_g;
    assign probe_b_o     = r_q.probe_b;
    assign probe_valid_o = r_q.probe_valid;
endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Receive-side companion to the VGA display generator. Samples the generated VGA stream (HS, VS, blank, 8-bit RGB) at pixel rate. Recovers horizontal and vertical timing, checks it against the 640x480 active geometry, and declares lock after consecutive consistent frames. Per frame it also reports a pixel checksum and captures one probed pixel, giving a self-check path for the display pipeline.

## Interface
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- CNT_W, 12, width of timing counters and measurements
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high; clears all state
- pix_en  in  1  pixel strobe; all sampling happens only on cycles with pix_en=1
- hs_in  in  1  horizontal sync, active-low
- vs_in  in  1  vertical sync, active-low
- blank_n_in  in  1  1 = active video pixel
- r_in, g_in, b_in  in  8 each  pixel colour
- probe_x  in  10  active-pixel column to capture
- probe_y  in  10  active-line row to capture
- h_total  out  CNT_W  pixels per line, last frame
- v_total  out  CNT_W  lines per frame, last frame
- h_active  out  CNT_W  active pixels per active line, last frame
- v_active  out  CNT_W  active lines, last frame
- locked  out  1  timing lock
- frame_done  out  1  one-clk pulse at each measured frame boundary
- err  out  1  one-clk pulse when a locked frame fails its checks
- frame_sum  out  32  sum of r+g+b over all active pixels of last frame, mod 2^32
- probe_r, probe_g, probe_b  out  8 each  captured pixel
- probe_valid  out  1  probe pixel was seen in last frame

## Operation
- Input stage: on pix_en, register hs/vs/blank_n/rgb into s1 and move the old s1 into s1_prev. All edges are detected as s1_prev=1, s1=0, evaluated only on pix_en cycles.
- Counters (saturate at 2^CNT_W-1):
  - hcnt: pixels since last HS fall
  - xact: active pixels in current line
  - vcnt: HS falls since last VS fall
  - yact: lines with xact>0
- HS fall:
  - Line length = hcnt+1. The first line after a VS fall sets ref_h. Any later line differing from ref_h sets bad.
  - A line with xact not in {0, H_ACTIVE} sets bad. A nonzero xact is stored as act_w.
  - Clear hcnt and xact. Increment yact if xact>0.
- Active pixel (s1 blank_n=1):
  - Add r+g+b to the running sum.
  - If xact==probe_x and yact==probe_y, capture RGB and set the seen flag.
  - Increment xact.
- States and transitions:
  - SEARCH (after reset): ignore data until the first VS fall, then go to MEASURE with lock_cnt=0.
  - VS fall in MEASURE or LOCKED (frame boundary):
    - Latch h_total=ref_h, v_total=vcnt, h_active=act_w, v_active=yact, frame_sum, probe_*, probe_valid=seen.
    - Pulse frame_done.
    - The frame is good iff: bad=0, yact==V_ACTIVE, act_w==H_ACTIVE, and (ref_h, vcnt) equal the previous frame's values.
    - Clear the per-frame state.
  - MEASURE: good frame increments lock_cnt; on reaching LOCK_FRAMES, enter LOCKED and set locked=1. Bad frame clears lock_cnt.
  - LOCKED: a bad frame pulses err, clears locked and lock_cnt, and returns to MEASURE.
- HS and VS falling on the same pix_en: process the line end first, then the frame end. That line counts toward the ending frame.

## Timing
- An edge appearing at the pins on pix_en k is acted on at pix_en k+1. Outputs update on that clk edge (latency: one pixel period plus one clk).
- frame_done and err are exactly one clk wide, independent of pix_en spacing.
- When pix_en=0, nothing changes except the clearing of the frame_done/err pulses.
- Reset values:
  - All outputs 0, state SEARCH, all counters and reference registers 0.
  - Reset asserted mid-frame discards that frame. The first frame_done after reset is produced by the second VS fall.
- Sum arithmetic: the 10-bit r+g+b is zero-extended and wraps mod 2^32.

## Test plan
- Standard 800x525 timing: HS low 96 px, active 640x480, pix_en every 2nd clk, constant RGB (10,20,30).
  - h_total=800, v_total=525, h_active=640, v_active=480.
  - frame_sum=18432000 per frame.
  - locked rises at the 3rd VS fall after reset.
- Probe test: probe (639,479), pixel (639,479)=(0xAB,0xCD,0xEF), all others 0.
  - probe_r/g/b=AB/CD/EF, probe_valid=1.
  - Probe (700,0) gives probe_valid=0.
- Glitch while locked: one line of 801 px.
  - At that frame's VS fall: err pulses once and locked=0.
  - locked returns after 2 further clean frames.
- Wrong geometry: frames with 479 active lines.
  - locked never asserts, err never pulses, v_active=479.
- Reset asserted mid-frame while locked:
  - All outputs 0 next clk.
  - No frame_done until the 2nd VS fall after release.
- pix_en held low for 1000 clks while sync/data toggle: all outputs and counters unchanged.
